// File: rtl/md_sched_if.sv
// Issue/result bundle between the E-stage operand path and the multiply/divide scheduler.
// The cancel signal exists only when MD_CANCEL_EN is defined.
interface md_sched_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             d_md_use;
`ifdef MD_CANCEL_EN
  logic             cancel;
`endif
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
`ifdef MD_CANCEL_EN
    output cancel,
`endif
    output start, op, src_a, src_b, d_md_use,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
`ifdef MD_CANCEL_EN
    input  cancel,
`endif
    input  start, op, src_a, src_b, d_md_use,
    output busy, stall_req, done, hi, lo
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, sequences fixed-latency mult/div with a down-counter.
// Optional abort of in-flight ops is enabled by defining MD_CANCEL_EN.
module md_sched #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned PROD_W     = 2 * WIDTH;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cancel_c;
  logic             is_signed_c;
  logic [PROD_W-1:0] a_ext_c, b_ext_c, prod_c;
  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, b_safe_c;
  logic [WIDTH-1:0] q_mag_c, r_mag_c, quo_c, rem_c;

`ifdef MD_CANCEL_EN
  assign cancel_c = bus.cancel;
`else
  assign cancel_c = 1'b0;
`endif

  // op_q[0] distinguishes the unsigned variants; op_q[1] selects divide.
  assign is_signed_c = ~op_q[0];

  // Full-width product of the latched operands, sign- or zero-extended first.
  always_comb begin
    a_ext_c = is_signed_c ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext_c = is_signed_c ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod_c  = a_ext_c * b_ext_c;
  end

  // Sign-magnitude divide: truncation toward zero, remainder takes the dividend's sign.
  // Taking magnitudes as unsigned also yields the MIN / -1 wrap to MIN with zero remainder.
  always_comb begin
    a_neg_c  = is_signed_c & a_q[WIDTH-1];
    b_neg_c  = is_signed_c & b_q[WIDTH-1];
    a_mag_c  = a_neg_c ? (~a_q + WIDTH'(1)) : a_q;
    b_mag_c  = b_neg_c ? (~b_q + WIDTH'(1)) : b_q;
    b_safe_c = (b_mag_c == '0) ? WIDTH'(1) : b_mag_c;
    q_mag_c  = a_mag_c / b_safe_c;
    r_mag_c  = a_mag_c % b_safe_c;
    quo_c    = (a_neg_c ^ b_neg_c) ? (~q_mag_c + WIDTH'(1)) : q_mag_c;
    rem_c    = a_neg_c ? (~r_mag_c + WIDTH'(1)) : r_mag_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !cancel_c) begin
          if (!bus.op[2]) begin
            op_d    = bus.op[1:0];
            a_d     = bus.src_a;
            b_d     = bus.src_b;
            cnt_d   = bus.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy_d  = 1'b1;
            state_d = RUN;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.src_a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.src_a;
          end
        end
      end

      RUN: begin
        // New issues are ignored here; stall_req keeps the core from sending them.
        if (cancel_c) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          if (!op_q[1]) begin
            hi_d = prod_c[PROD_W-1:WIDTH];
            lo_d = prod_c[WIDTH-1:0];
          end else if (b_q != '0) begin
            hi_d = rem_c;
            lo_d = quo_c;
          end
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.stall_req = bus.d_md_use & (busy_q | (bus.start & ~bus.op[2]));

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
// Cancel scenario is compiled in when MD_CANCEL_EN is defined.
module tb_md_sched;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  md_sched_if #(.WIDTH(32)) bus ();

  md_sched #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are checked 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.op       = 3'd7;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.d_md_use = 1'b0;
`ifdef MD_CANCEL_EN
    bus.cancel   = 1'b0;
`endif
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    bus.d_md_use = 1'b1;
    tick();
    tick();
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy=%b done=%b, expected 0 0", bus.busy, bus.done);
    end
    n_checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_hilo: hi=%h lo=%h, expected 0 0", bus.hi, bus.lo);
    end
    n_checks++;
    if (bus.stall_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: stall_req=%b, expected 0", bus.stall_req);
    end
    bus.d_md_use = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL mult_busy_c0: busy=%b, expected 0", bus.busy);
    end
    tick();
    idle_inputs();
    for (int c = 1; c <= 5; c++) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++; $display("FAIL mult_busy_c%0d: busy=%b done=%b, expected 1 0", c, bus.busy, bus.done);
      end
      tick();
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      n_fail++; $display("FAIL mult_done_c6: busy=%b done=%b, expected 0 1", bus.busy, bus.done);
    end
    n_checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
      n_fail++; $display("FAIL mult_result: hi=%h lo=%h, expected ffffffff fffffffa", bus.hi, bus.lo);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL mult_done_c7: done=%b, expected 0", bus.done);
    end
  endtask

  task automatic test_divu_stall();
    bus.d_md_use = 1'b1;
    issue(3'd3, 32'd17, 32'd5);
    #1;
    n_checks++;
    if (bus.stall_req !== 1'b1) begin
      n_fail++; $display("FAIL divu_stall_c0: stall_req=%b, expected 1", bus.stall_req);
    end
    tick();
    bus.start = 1'b0;
    bus.op    = 3'd7;
    for (int c = 1; c <= 10; c++) begin
      #1;
      n_checks++;
      if (bus.stall_req !== 1'b1 || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL divu_stall_c%0d: stall_req=%b busy=%b, expected 1 1", c, bus.stall_req, bus.busy);
      end
      tick();
    end
    #1;
    n_checks++;
    if (bus.stall_req !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      n_fail++; $display("FAIL divu_end_c11: stall_req=%b busy=%b done=%b, expected 0 0 1", bus.stall_req, bus.busy, bus.done);
    end
    n_checks++;
    if (bus.lo !== 32'd3 || bus.hi !== 32'd2) begin
      n_fail++; $display("FAIL divu_result: hi=%h lo=%h, expected 2 3", bus.hi, bus.lo);
    end
    idle_inputs();
    tick();
  endtask

  // Runs one op to completion within a bounded window; reports busy length, done seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles, output int done_count);
    busy_cycles = 0;
    done_count  = 0;
    issue(op, a, b);
    tick();
    idle_inputs();
    for (int c = 0; c < 30; c++) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.done === 1'b1) done_count++;
      if (bus.done === 1'b1) break;
      tick();
    end
  endtask

  task automatic test_div_signed();
    int bc, dc;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, bc, dc);
    n_checks++;
    if (bc != 10 || dc != 1) begin
      n_fail++; $display("FAIL div_timing: busy_cycles=%0d done=%0d, expected 10 1", bc, dc);
    end
    n_checks++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL div_result: hi=%h lo=%h, expected ffffffff fffffffd", bus.hi, bus.lo);
    end
    tick();
    run_op(3'd2, 32'd1234, 32'd0, bc, dc);
    n_checks++;
    if (bc != 10 || dc != 1) begin
      n_fail++; $display("FAIL div0_timing: busy_cycles=%0d done=%0d, expected 10 1", bc, dc);
    end
    n_checks++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL div0_keep: hi=%h lo=%h, expected ffffffff fffffffd", bus.hi, bus.lo);
    end
    tick();
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
    n_checks++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0 || dc != 1) begin
      n_fail++; $display("FAIL div_overflow: hi=%h lo=%h done=%0d, expected 0 80000000 1", bus.hi, bus.lo, dc);
    end
    tick();
  endtask

  task automatic test_multu();
    int bc, dc;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
    n_checks++;
    if (bc != 5 || dc != 1) begin
      n_fail++; $display("FAIL multu_timing: busy_cycles=%0d done=%0d, expected 5 1", bc, dc);
    end
    n_checks++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      n_fail++; $display("FAIL multu_result: hi=%h lo=%h, expected fffffffe 00000001", bus.hi, bus.lo);
    end
    tick();
  endtask

  task automatic test_mthi_mtlo();
    bus.d_md_use = 1'b1;
    issue(3'd4, 32'h1234_5678, 32'h0);
    #1;
    n_checks++;
    if (bus.stall_req !== 1'b0) begin
      n_fail++; $display("FAIL mthi_stall: stall_req=%b, expected 0", bus.stall_req);
    end
    tick();
    issue(3'd5, 32'h9ABC_DEF0, 32'h0);
    #1;
    n_checks++;
    if (bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      n_fail++; $display("FAIL mthi_write: hi=%h busy=%b stall_req=%b, expected 12345678 0 0", bus.hi, bus.busy, bus.stall_req);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.lo !== 32'h9ABC_DEF0 || bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL mtlo_write: hi=%h lo=%h busy=%b done=%b, expected 12345678 9abcdef0 0 0", bus.hi, bus.lo, bus.busy, bus.done);
    end
    tick();
  endtask

`ifdef MD_CANCEL_EN
  task automatic test_cancel();
    int dc;
    dc = 0;
    issue(3'd1, 32'd3, 32'd4);
    tick();
    idle_inputs();
    tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL cancel_busy: busy=%b, expected 0", bus.busy);
    end
    for (int c = 0; c < 8; c++) begin
      if (bus.done === 1'b1) dc++;
      tick();
    end
    n_checks++;
    if (dc != 0 || bus.hi !== 32'h1234_5678 || bus.lo !== 32'h9ABC_DEF0) begin
      n_fail++; $display("FAIL cancel_keep: done=%0d hi=%h lo=%h, expected 0 12345678 9abcdef0", dc, bus.hi, bus.lo);
    end
    issue(3'd4, 32'hDEAD_BEEF, 32'h0);
    bus.cancel = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL cancel_idle: hi=%h busy=%b, expected 12345678 0", bus.hi, bus.busy);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int bc, dc;
    bc = 0;
    dc = 0;
    issue(3'd0, 32'd6, 32'd7);
    tick();
    idle_inputs();
    tick();
    issue(3'd3, 32'd100, 32'd7);
    for (int c = 2; c <= 20; c++) begin
      if (bus.busy === 1'b1) bc++;
      if (bus.done === 1'b1) dc++;
      tick();
      idle_inputs();
    end
    n_checks++;
    if (bc != 4 || dc != 1) begin
      n_fail++; $display("FAIL b2b_timing: busy_cycles_from_c2=%0d done=%0d, expected 4 1", bc, dc);
    end
    n_checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'd42) begin
      n_fail++; $display("FAIL b2b_result: hi=%h lo=%h, expected 0 2a", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid();
    int bc;
    bc = 0;
    issue(3'd2, 32'd1000, 32'd3);
    tick();
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h done=%b, expected 0 0 0 0", bus.busy, bus.hi, bus.lo, bus.done);
    end
    tick();
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.busy === 1'b1 || bus.done === 1'b1) bc++;
    end
    n_checks++;
    if (bc != 0 || bus.lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_discard: active_cycles=%0d lo=%h, expected 0 0", bc, bus.lo);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle_inputs();
    test_reset();
    test_mult();
    test_divu_stall();
    test_div_signed();
    test_multu();
    test_mthi_mtlo();
`ifdef MD_CANCEL_EN
    test_cancel();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
